// File: rtl/movement_pkg.sv
// movement_pkg: control-code encoding shared by movement_control and the
// sprite datapath, so both ends agree on what each 4-bit code means.
//   CTRL_*  : 4-bit control codes driven on movement_control.control
//   state_t : FSM state type whose encoding equals the control code
package movement_pkg;

    localparam logic [3:0] CTRL_PREHOLD = 4'b0100;
    localparam logic [3:0] CTRL_HOLD    = 4'b0000;
    localparam logic [3:0] CTRL_CLEAR   = 4'b0001;
    localparam logic [3:0] CTRL_LEFT    = 4'b0011;
    localparam logic [3:0] CTRL_RIGHT   = 4'b0010;
    localparam logic [3:0] CTRL_DOWN    = 4'b0110;
    localparam logic [3:0] CTRL_UP      = 4'b0111;
    localparam logic [3:0] CTRL_DRAW    = 4'b0101;

    typedef enum logic [3:0] {
        StPrehold = CTRL_PREHOLD,
        StHold    = CTRL_HOLD,
        StClear   = CTRL_CLEAR,
        StLeft    = CTRL_LEFT,
        StRight   = CTRL_RIGHT,
        StDown    = CTRL_DOWN,
        StUp      = CTRL_UP,
        StDraw    = CTRL_DRAW
    } state_t;

endpackage

// File: rtl/key_sync.sv
// key_sync: two-flop synchroniser for a bus of independent asynchronous
// single-bit inputs. Each bit is synchronised separately; no bus coherency.
//   clk   : destination clock
//   reset : asynchronous active-high reset, clears both flop stages
//   d     : asynchronous inputs
//   q     : synchronised outputs (2-cycle latency)
module key_sync #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;
    logic [WIDTH-1:0] sync;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= '0;
            sync <= '0;
        end else begin
            meta <= d;
            sync <= meta;
        end
    end

    assign q = sync;

endmodule

// File: rtl/movement_control.sv
// movement_control: control FSM for the sprite movement datapath. Paces moves
// to a frame tick, sequences erase -> move -> redraw, and guards each datapath
// pass with a done timeout.
//   clk                : system clock, rising edge
//   reset              : asynchronous active-high reset
//   key_left/right/up/down : raw asynchronous direction requests
//   done               : one-cycle end-of-pass pulse from the datapath
//   control            : state code to the datapath (equals the state register)
//   busy               : high in every state except HOLD
//   timeout_err        : sticky done-timeout flag, cleared only by reset
module movement_control
    import movement_pkg::*;
#(
    parameter int unsigned FRAME_DIV    = 833333,
    parameter int unsigned DONE_TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_left,
    input  logic       key_right,
    input  logic       key_up,
    input  logic       key_down,
    input  logic       done,
    output logic [3:0] control,
    output logic       busy,
    output logic       timeout_err
);

    localparam int unsigned FW = $clog2(FRAME_DIV);
    localparam int unsigned WW = $clog2(DONE_TIMEOUT + 1);

    // Key bit order: [0] left, [1] right, [2] up, [3] down.
    logic [3:0] key_raw;
    logic [3:0] key_s;
    logic [3:0] req_q, req_d;

    logic [FW-1:0] frame_cnt_q, frame_cnt_d;
    logic          tick;

    logic [WW-1:0] wait_cnt_q, wait_cnt_d;
    logic          waiting;
    logic          timeout;

    state_t state_q, state_d;
    logic   err_q, err_d;

    // Move decode: opposing keys cancel.
    logic   key_h_ok, key_v_ok, req_h_ok, req_v_ok;
    state_t req_h_st, req_v_st;

    assign key_raw = {key_down, key_up, key_right, key_left};

    key_sync #(
        .WIDTH (4)
    ) u_key_sync (
        .clk   (clk),
        .reset (reset),
        .d     (key_raw),
        .q     (key_s)
    );

    // Frame counter: free-running in every state; ticks outside HOLD are lost.
    assign tick        = (frame_cnt_q == FW'(FRAME_DIV - 1));
    assign frame_cnt_d = tick ? '0 : frame_cnt_q + 1'b1;

    assign key_h_ok = key_s[0] ^ key_s[1];
    assign key_v_ok = key_s[2] ^ key_s[3];
    assign req_h_ok = req_q[0] ^ req_q[1];
    assign req_v_ok = req_q[2] ^ req_q[3];
    assign req_h_st = req_q[0] ? StLeft : StRight;
    assign req_v_st = req_q[2] ? StUp : StDown;

    // Keys are captured only when a tick is consumed in HOLD.
    assign req_d = (state_q == StHold && tick) ? key_s : req_q;

    assign waiting = (state_q == StClear) || (state_q == StDraw);
    assign timeout = waiting && (wait_cnt_q == WW'(DONE_TIMEOUT - 1));

    // Cleared on any state change so each CLEAR/DRAW entry starts from zero.
    assign wait_cnt_d = (waiting && state_d == state_q) ? wait_cnt_q + 1'b1 : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StPrehold;
            frame_cnt_q <= '0;
            wait_cnt_q  <= '0;
            req_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            frame_cnt_q <= frame_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            req_q       <= req_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        unique case (state_q)
            StPrehold: state_d = StDraw;
            StHold: begin
                // Decision uses the keys being latched this cycle.
                if (tick && (key_h_ok || key_v_ok)) begin
                    state_d = StClear;
                end
            end
            StClear: begin
                // done beats a same-cycle timeout.
                if (done) begin
                    if (req_h_ok) begin
                        state_d = req_h_st;
                    end else if (req_v_ok) begin
                        state_d = req_v_st;
                    end else begin
                        state_d = StDraw;
                    end
                end else if (timeout) begin
                    state_d = StHold;
                    err_d   = 1'b1;
                end
            end
            StLeft, StRight: state_d = req_v_ok ? req_v_st : StDraw;
            StUp, StDown:    state_d = StDraw;
            StDraw: begin
                if (done) begin
                    state_d = StHold;
                end else if (timeout) begin
                    state_d = StHold;
                    err_d   = 1'b1;
                end
            end
            default: state_d = StPrehold;
        endcase
    end

    always_comb begin
        control     = state_q;
        busy        = (state_q != StHold);
        timeout_err = err_q;
    end

endmodule
